// File: rtl/serial_slave_port_if.sv
// Serial slave port bundle: bit-serial bus side plus the local memory side.
// Ports: mwdata/mmode/mvalid (bus in), srdata/svalid/sready (bus out),
//        mem_addr/mem_wdata/mem_wen (memory out), mem_rdata (memory in).
interface serial_slave_port_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  mwdata;
  logic                  mmode;
  logic                  mvalid;
  logic                  srdata;
  logic                  svalid;
  logic                  sready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // The port itself.
  modport slave (
    input  mwdata, mmode, mvalid, mem_rdata,
    output srdata, svalid, sready, mem_addr, mem_wdata, mem_wen
  );

  // Bus master plus local memory, i.e. everything around the port.
  modport master (
    output mwdata, mmode, mvalid, mem_rdata,
    input  srdata, svalid, sready, mem_addr, mem_wdata, mem_wen
  );
endinterface

// File: rtl/serial_slave_port.sv
// Serial slave port: receives a bit-serial address (and write data, LSB first)
// and performs one local memory write, or a read whose word is shifted back out.
// Ports: clk, rstn (sync, active-low), bus (serial_slave_port_if.slave).
module serial_slave_port #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rstn,
  serial_slave_port_if.slave  bus
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  // MEM_LATENCY <= 4 always fits: CNT_W >= 2 for the smallest widths.
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(MEM_LATENCY - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] RWAIT = 3'd4;
  localparam logic [2:0] RSEND = 3'd5;

  logic [2:0]            state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  mode_q,      mode_d;
  logic [ADDR_WIDTH-1:0] addr_sr_q,   addr_sr_d;
  logic [DATA_WIDTH-1:0] wdata_sr_q,  wdata_sr_d;
  logic [DATA_WIDTH-1:0] rdata_sr_q,  rdata_sr_d;
  logic                  srdata_q,    srdata_d;
  logic                  svalid_q,    svalid_d;
  logic                  sready_q,    sready_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_wen_q,   mem_wen_d;

  // Incoming bits enter at the MSB and shift down, so after the final bit
  // the first (LSB) bit has landed in position 0.
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [DATA_WIDTH-1:0] wdata_shift;
  assign addr_shift  = {bus.mwdata, addr_sr_q[ADDR_WIDTH-1:1]};
  assign wdata_shift = {bus.mwdata, wdata_sr_q[DATA_WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    addr_sr_d   = addr_sr_q;
    wdata_sr_d  = wdata_sr_q;
    rdata_sr_d  = rdata_sr_q;
    srdata_d    = srdata_q;
    svalid_d    = svalid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wen_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mvalid) begin
          addr_sr_d = addr_shift;
          mode_d    = bus.mmode;
          cnt_d     = CNT_ONE;
          state_d   = ADDR;
        end
      end

      ADDR: begin
        if (bus.mvalid) begin
          addr_sr_d = addr_shift;
          if (cnt_q == ADDR_LAST) begin
            mem_addr_d = addr_shift;
            cnt_d      = '0;
            state_d    = mode_q ? WDATA : RWAIT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      WDATA: begin
        if (bus.mvalid) begin
          wdata_sr_d = wdata_shift;
          if (cnt_q == DATA_LAST) begin
            mem_wdata_d = wdata_shift;
            mem_wen_d   = 1'b1;
            cnt_d       = '0;
            state_d     = WRITE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      WRITE: begin
        // mem_wen_q is high for this single cycle; it drops by default.
        state_d = IDLE;
      end

      RWAIT: begin
        // Counts cycles unconditionally; mvalid has no meaning here.
        if (cnt_q == LAT_LAST) begin
          // Bit 0 goes straight to srdata; the rest waits in the shifter.
          srdata_d   = bus.mem_rdata[0];
          rdata_sr_d = bus.mem_rdata >> 1;
          svalid_d   = 1'b1;
          cnt_d      = '0;
          state_d    = RSEND;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RSEND: begin
        if (cnt_q == DATA_LAST) begin
          srdata_d = 1'b0;
          svalid_d = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          srdata_d   = rdata_sr_q[0];
          rdata_sr_d = rdata_sr_q >> 1;
          cnt_d      = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d    = '0;
        svalid_d = 1'b0;
        srdata_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    sready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      addr_sr_q   <= '0;
      wdata_sr_q  <= '0;
      rdata_sr_q  <= '0;
      srdata_q    <= 1'b0;
      svalid_q    <= 1'b0;
      sready_q    <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      addr_sr_q   <= addr_sr_d;
      wdata_sr_q  <= wdata_sr_d;
      rdata_sr_q  <= rdata_sr_d;
      srdata_q    <= srdata_d;
      svalid_q    <= svalid_d;
      sready_q    <= sready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wen_q   <= mem_wen_d;
    end
  end

  assign bus.srdata    = srdata_q;
  assign bus.svalid    = svalid_q;
  assign bus.sready    = sready_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wen   = mem_wen_q;

endmodule

// File: tb/tb_serial_slave_port.sv
// Bench for serial_slave_port: directed transfers with a scoreboard queue
// filled by the driver and drained by an independent output monitor.
// Ports: none (top level); owns the interface, clock, reset and memory model.
module tb_serial_slave_port;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int LAT = 2;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t sbq[$];
  bit   rd_active = 1'b0;

  serial_slave_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  serial_slave_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Local memory: read data becomes valid one edge after the address moves,
  // so it is only correct by the LAT-th edge, not earlier.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_stage;
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[12'h002] = 8'h3C;
  end
  always @(posedge clk) begin
    if (bus_if.mem_wen) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
    rd_stage <= mem[bus_if.mem_addr];
  end
  assign bus_if.mem_rdata = rd_stage;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the port writes memory or starts
  // sending read data.
  initial begin
    exp_t          cur;
    logic [15:0]   rd_word;
    int            rd_n;
    rd_word = '0;
    rd_n    = 0;
    forever begin
      @(negedge clk);
      if (bus_if.mem_wen) begin
        if (sbq.size() == 0 || !sbq[0].wr) begin
          chk("unexpected_mem_wen", 32'(bus_if.mem_wen), 0);
        end else begin
          cur = sbq.pop_front();
          chk("wr_addr", 32'(bus_if.mem_addr), 32'(cur.addr));
          chk("wr_data", 32'(bus_if.mem_wdata), 32'(cur.data));
          chk("wr_cycle", cyc, cur.cyc);
          chk("sready_in_write", 32'(bus_if.sready), 0);
        end
      end
      if (rd_active) begin
        if (!bus_if.svalid) begin
          chk("svalid_run", 32'(bus_if.svalid), 1);
          rd_active = 1'b0;
        end else begin
          rd_word[rd_n] = bus_if.srdata;
          rd_n++;
          if (rd_n == DW) begin
            chk("rd_data", 32'(rd_word), 32'(cur.data));
            rd_active = 1'b0;
          end
        end
      end else if (bus_if.svalid) begin
        if (sbq.size() == 0 || sbq[0].wr) begin
          chk("unexpected_svalid", 32'(bus_if.svalid), 0);
        end else begin
          cur = sbq.pop_front();
          chk("rd_start_cycle", cyc, cur.cyc);
          chk("sready_in_rsend", 32'(bus_if.sready), 0);
          rd_word    = '0;
          rd_word[0] = bus_if.srdata;
          rd_n       = 1;
          rd_active  = 1'b1;
        end
      end
    end
  end

  task automatic idle(input int n);
    bus_if.mvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One transfer. Bits after the first carry a random mmode to show it is
  // ignored; limit < total bits leaves the transfer unfinished (no expectation).
  task automatic xfer(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                      input bit gapped, input int limit);
    logic [31:0] bits;
    int          total;
    int          last;
    exp_t        e;
    total = wr ? AW + DW : AW;
    bits  = 32'(addr[AW-1:0]) | (32'(data[DW-1:0]) << AW);
    last  = 0;
    for (int i = 0; i < total && i < limit; i++) begin
      bus_if.mvalid = 1'b1;
      bus_if.mwdata = bits[i];
      bus_if.mmode  = (i == 0) ? wr : 1'($urandom_range(0, 1));
      last = cyc;
      @(posedge clk);
      #1;
      if (gapped && i != total - 1) begin
        bus_if.mvalid = 1'b0;
        bus_if.mwdata = 1'($urandom_range(0, 1));
        bus_if.mmode  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    end
    bus_if.mvalid = 1'b0;
    if (limit < total) return;
    e.wr   = wr;
    e.addr = addr;
    e.data = data;
    e.cyc  = wr ? last + 1 : last + LAT + 1;
    sbq.push_back(e);
    // Noise during WRITE / RWAIT / RSEND that the port must ignore.
    repeat (wr ? 1 : LAT + DW) begin
      bus_if.mvalid = 1'b1;
      bus_if.mwdata = 1'($urandom_range(0, 1));
      bus_if.mmode  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus_if.mvalid = 1'b0;
  endtask

  initial begin
    rstn          = 1'b0;
    bus_if.mvalid = 1'b0;
    bus_if.mwdata = 1'b0;
    bus_if.mmode  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sready",    32'(bus_if.sready),    1);
    chk("rst_svalid",    32'(bus_if.svalid),    0);
    chk("rst_srdata",    32'(bus_if.srdata),    0);
    chk("rst_mem_wen",   32'(bus_if.mem_wen),   0);
    chk("rst_mem_addr",  32'(bus_if.mem_addr),  0);
    chk("rst_mem_wdata", 32'(bus_if.mem_wdata), 0);
    rstn = 1'b1;
    idle(2);

    xfer(1'b1, 16'h009, 16'hA5, 1'b0, 99);   // continuous write
    xfer(1'b0, 16'h002, 16'h3C, 1'b0, 99);   // read of preloaded word
    idle(3);
    xfer(1'b1, 16'hFFF, 16'h01, 1'b1, 99);   // gapped write, top address
    xfer(1'b0, 16'hFFF, 16'h01, 1'b0, 99);   // read it back
    idle(2);

    // Abort a write after 4 data bits with a one-cycle reset.
    xfer(1'b1, 16'h123, 16'h5A, 1'b0, AW + 4);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("abort_sready",  32'(bus_if.sready),  1);
    chk("abort_mem_wen", 32'(bus_if.mem_wen), 0);
    idle(3);
    xfer(1'b0, 16'h009, 16'hA5, 1'b0, 99);   // earlier write intact
    xfer(1'b0, 16'h123, 16'h00, 1'b0, 99);   // aborted write never landed

    // Back-to-back: the read starts in the first IDLE cycle after WRITE.
    xfer(1'b1, 16'h001, 16'h7E, 1'b0, 99);
    xfer(1'b0, 16'h001, 16'h7E, 1'b0, 99);

    for (int i = 0; i < 200 && (sbq.size() != 0 || rd_active); i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()) + 32'(rd_active), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
